// File: rtl/tinydds_spi_pkg.sv
// rtl/tinydds_spi_pkg.sv - shared constants, frame sizing and tracker state for the SPI register bank
package tinydds_spi_pkg;

  localparam logic RW_WRITE        = 1'b0;
  localparam logic RW_READ         = 1'b1;
  localparam int   CTRL_ADDR       = 0;
  localparam int   CTRL_COMMIT_BIT = 0;

  typedef enum logic {
    TRK_IDLE  = 1'b0,
    TRK_ARMED = 1'b1
  } trk_state_t;

  function automatic int frame_bits(input int addr_width, input int data_width);
    return 1 + addr_width + data_width;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with registered rise/fall pulses
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  // The chain is left unreset so a reset never fabricates an edge on a pin that is mid-transfer.
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], raw};
  end

  assign level = chain[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= chain[STAGES-2] & ~chain[STAGES-1];
      fall <= ~chain[STAGES-2] & chain[STAGES-1];
    end
  end

endmodule

// File: rtl/spi_slave_regbank.sv
// rtl/spi_slave_regbank.sv - SPI mode-0 slave with shadow/active register file, commit and readback
module spi_slave_regbank
  import tinydds_spi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 28,
  parameter int NUM_REGS    = 7,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_COMMIT = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           spi_clock,
  input  logic                           spi_cs_n,
  input  logic                           spi_mosi,
  output logic                           spi_miso,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_active,
  output logic                           update_stb,
  output logic                           frame_error
);

  localparam int FRAME_BITS = frame_bits(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_WIDTH);
  localparam logic             AUTO     = (AUTO_COMMIT != 0);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (spi_clock),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  trk_state_t state_q, state_d;
  logic       armed, shift_en, frame_end;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= TRK_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TRK_IDLE:  if (cs_fall) state_d = TRK_ARMED;
      TRK_ARMED: if (cs_rise) state_d = TRK_IDLE;
      default:   state_d = TRK_IDLE;
    endcase
  end

  // A cs_n rise coinciding with an sclk rise still shifts; the frame end then sees the updated count.
  always_comb begin
    armed     = (state_q == TRK_ARMED);
    shift_en  = armed & sclk_rise;
    frame_end = armed & cs_rise;
  end

  logic [CNT_W-1:0]      cnt_q, cnt_next;
  logic [FRAME_BITS-1:0] rx_q, rx_next;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  reading_q;
  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] active [NUM_REGS];

  logic                  f_rw, hdr_rw;
  logic [ADDR_WIDTH-1:0] f_addr, hdr_addr;
  logic [DATA_WIDTH-1:0] f_data, rd_word;
  logic                  frame_ok, wr_hit, wr_valid, commit, load_tx;

  always_comb begin
    cnt_next = cnt_q;
    rx_next  = rx_q;
    if (shift_en) begin
      rx_next = {rx_q[FRAME_BITS-2:0], mosi_level};
      if (cnt_q != CNT_SAT) cnt_next = cnt_q + 1'b1;
    end
  end

  always_comb begin
    f_rw     = rx_next[FRAME_BITS-1];
    f_addr   = rx_next[FRAME_BITS-2 -: ADDR_WIDTH];
    f_data   = rx_next[DATA_WIDTH-1:0];
    hdr_rw   = rx_next[ADDR_WIDTH];
    hdr_addr = rx_next[ADDR_WIDTH-1:0];
    frame_ok = frame_end && (cnt_next == CNT_FULL);
    wr_hit   = frame_ok && (f_rw == RW_WRITE);
    wr_valid = wr_hit && (f_addr != ADDR_WIDTH'(CTRL_ADDR)) &&
               (f_addr <= ADDR_WIDTH'(NUM_REGS));
    commit   = wr_hit && (f_addr == ADDR_WIDTH'(CTRL_ADDR)) && f_data[CTRL_COMMIT_BIT];
    load_tx  = shift_en && (cnt_q == CNT_ADDR);
  end

  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (hdr_addr == ADDR_WIDTH'(r + 1)) rd_word = shadow[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rx_q  <= '0;
    end else begin
      cnt_q <= cs_fall ? '0 : cnt_next;
      rx_q  <= rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        shadow[r] <= '0;
        active[r] <= '0;
      end
      update_stb  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_valid && (f_addr == ADDR_WIDTH'(r + 1))) begin
          shadow[r] <= f_data;
          if (AUTO) active[r] <= f_data;
        end
        if (commit) active[r] <= shadow[r];
      end
      update_stb  <= commit || (wr_valid && AUTO);
      frame_error <= frame_end && (cnt_next != CNT_FULL);
    end
  end

  // MISO is held low outside an armed frame and on write frames; readback starts after the header.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q      <= '0;
      reading_q <= 1'b0;
      spi_miso  <= 1'b0;
    end else if (!armed || cs_level) begin
      tx_q      <= '0;
      reading_q <= 1'b0;
      spi_miso  <= 1'b0;
    end else if (load_tx) begin
      tx_q      <= (hdr_rw == RW_READ) ? rd_word : '0;
      reading_q <= (hdr_rw == RW_READ);
    end else if (sclk_fall && reading_q) begin
      spi_miso <= tx_q[DATA_WIDTH-1];
      tx_q     <= {tx_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    regs_active = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_active[r*DATA_WIDTH +: DATA_WIDTH] = active[r];
    end
  end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb/tb_spi_slave_regbank.sv - randomized frame-level checks of spi_slave_regbank against a register model
module tb_spi_slave_regbank;

  localparam int NR   = 7;
  localparam int DW   = 28;
  localparam int FB   = 33;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_clock = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;

  logic             spi_miso, update_stb, frame_error;
  logic [NR*DW-1:0] dut_regs;
  logic             miso_ac, stb_ac, err_ac;
  logic [NR*DW-1:0] ac_regs;

  always #5 clk = ~clk;

  spi_slave_regbank #(.AUTO_COMMIT(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clock   (spi_clock),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .regs_active (dut_regs),
    .update_stb  (update_stb),
    .frame_error (frame_error)
  );

  spi_slave_regbank #(.AUTO_COMMIT(1)) dut_ac (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clock   (spi_clock),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (miso_ac),
    .regs_active (ac_regs),
    .update_stb  (stb_ac),
    .frame_error (err_ac)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_stb = 0, n_stb_ac = 0, n_err = 0, n_err_ac = 0;
  int exp_stb = 0, exp_stb_ac = 0, exp_err = 0;

  logic [DW-1:0] m_sh     [16];
  logic [DW-1:0] m_act    [16];
  logic [DW-1:0] m_ac_act [16];
  logic [63:0]   exp_v, got_v;

  always @(negedge clk) begin
    if (update_stb)  n_stb++;
    if (stb_ac)      n_stb_ac++;
    if (frame_error) n_err++;
    if (err_ac)      n_err_ac++;
  end

  function automatic logic [63:0] fw(input logic rw, input int a, input logic [DW-1:0] d);
    logic [63:0] w;
    w = '0;
    w[32] = rw;
    w[31:28] = 4'(a);
    w[27:0] = d;
    return w;
  endfunction

  function automatic logic [NR*DW-1:0] pack_regs(input bit ac);
    logic [NR*DW-1:0] v;
    v = '0;
    for (int r = 1; r <= NR; r++) v[r*DW-1 -: DW] = ac ? m_ac_act[r] : m_act[r];
    return v;
  endfunction

  // Master samples MISO on each rising edge; data follows the 5 header bits, MSB first.
  function automatic logic [63:0] exp_miso(input int nbits, input logic [63:0] word);
    logic [63:0]   v;
    logic [3:0]    a;
    logic [DW-1:0] rd;
    v = '0;
    if (nbits >= 5 && word[nbits-1] == 1'b1) begin
      a  = 4'(word >> (nbits - 5));
      rd = (a >= 1 && a <= NR) ? m_sh[a] : '0;
      for (int k = 6; k <= nbits && k <= FB; k++) v[nbits-k] = rd[DW-1-(k-6)];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_sh[r] = '0;
      m_act[r] = '0;
      m_ac_act[r] = '0;
    end
  endtask

  task automatic model_frame(input int nbits, input logic [63:0] word);
    logic [3:0]    a;
    logic [DW-1:0] d;
    if (nbits != FB) begin
      exp_err++;
      return;
    end
    a = word[31:28];
    d = word[27:0];
    if (word[32] == 1'b0) begin
      if (a >= 1 && a <= NR) begin
        m_sh[a] = d;
        m_ac_act[a] = d;
        exp_stb_ac++;
      end else if (a == 0 && d[0]) begin
        for (int r = 1; r <= NR; r++) begin
          m_act[r] = m_sh[r];
          m_ac_act[r] = m_sh[r];
        end
        exp_stb++;
        exp_stb_ac++;
      end
    end
  endtask

  task automatic spi_xfer(input int nbits, input logic [63:0] word, input int rst_after,
                          output logic [63:0] miso_bits);
    miso_bits = '0;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = word[i];
      repeat (HALF) @(negedge clk);
      spi_clock = 1'b1;
      miso_bits[i] = spi_miso;
      repeat (HALF) @(negedge clk);
      spi_clock = 1'b0;
      if (nbits - i == rst_after) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic run_frame(input int nbits, input logic [63:0] word, input int rst_after);
    exp_v = exp_miso(nbits, word);
    spi_xfer(nbits, word, rst_after, got_v);
    if (rst_after >= 0) model_reset();
    else model_frame(nbits, word);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (dut_regs !== '0) begin n_bad++; $display("FAIL reset_regs got=%h want=0", dut_regs); end
    n_vec++; if (ac_regs !== '0) begin n_bad++; $display("FAIL reset_ac_regs got=%h want=0", ac_regs); end
    n_vec++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso got=%b want=0", spi_miso); end
    n_vec++; if (update_stb !== 1'b0 || frame_error !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses stb=%b err=%b want=0/0", update_stb, frame_error);
    end
  endtask

  task automatic test_commit();
    int s0;
    s0 = n_stb;
    run_frame(FB, fw(1'b0, 1, 28'h1234567), -1);
    n_vec++; if (dut_regs !== '0) begin n_bad++; $display("FAIL commit_pre_regs got=%h want=0", dut_regs); end
    n_vec++; if (n_stb !== s0) begin n_bad++; $display("FAIL commit_pre_stb got=%0d want=%0d", n_stb - s0, 0); end
    run_frame(FB, fw(1'b1, 1, '0), -1);
    n_vec++; if (got_v !== exp_v) begin n_bad++; $display("FAIL commit_shadow_read got=%h want=%h", got_v, exp_v); end
    run_frame(FB, fw(1'b0, 0, 28'h1), -1);
    n_vec++; if (dut_regs[27:0] !== 28'h1234567) begin
      n_bad++; $display("FAIL commit_reg1 got=%h want=1234567", dut_regs[27:0]);
    end
    n_vec++; if (n_stb - s0 !== 1) begin n_bad++; $display("FAIL commit_stb_count got=%0d want=1", n_stb - s0); end
    n_vec++; if (dut_regs !== pack_regs(0)) begin n_bad++; $display("FAIL commit_regs got=%h want=%h", dut_regs, pack_regs(0)); end
  endtask

  task automatic test_auto_commit();
    int s0;
    s0 = n_stb_ac;
    run_frame(FB, fw(1'b0, 7, 28'hABCDEF0), -1);
    n_vec++; if (ac_regs[195:168] !== 28'hABCDEF0) begin
      n_bad++; $display("FAIL auto_reg7 got=%h want=abcdef0", ac_regs[195:168]);
    end
    n_vec++; if (n_stb_ac - s0 !== 1) begin n_bad++; $display("FAIL auto_stb_count got=%0d want=1", n_stb_ac - s0); end
    n_vec++; if (dut_regs !== pack_regs(0)) begin n_bad++; $display("FAIL auto_manual_regs got=%h want=%h", dut_regs, pack_regs(0)); end
  endtask

  task automatic test_readback();
    n_vec++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL read_idle_miso got=%b want=0", spi_miso); end
    run_frame(FB, fw(1'b0, 3, 28'h0000FFF), -1);
    run_frame(FB, fw(1'b1, 3, '0), -1);
    n_vec++; if (got_v[27:0] !== 28'h0000FFF) begin n_bad++; $display("FAIL read_data got=%h want=0000fff", got_v[27:0]); end
    n_vec++; if (got_v !== exp_v) begin n_bad++; $display("FAIL read_frame got=%h want=%h", got_v, exp_v); end
    n_vec++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL read_after_miso got=%b want=0", spi_miso); end
  endtask

  task automatic test_bad_length();
    logic [63:0] w;
    int e0, s0;
    e0 = n_err;
    s0 = n_stb_ac;
    w = fw(1'b0, 2, 28'h5A5A5A5);
    run_frame(32, w >> 1, -1);
    n_vec++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL short_err_count got=%0d want=1", n_err - e0); end
    run_frame(34, w << 1, -1);
    n_vec++; if (n_err - e0 !== 2) begin n_bad++; $display("FAIL long_err_count got=%0d want=2", n_err - e0); end
    n_vec++; if (n_stb_ac !== s0) begin n_bad++; $display("FAIL badlen_stb got=%0d want=0", n_stb_ac - s0); end
    run_frame(FB, fw(1'b1, 2, '0), -1);
    n_vec++; if (got_v !== 64'h0) begin n_bad++; $display("FAIL badlen_reg2 got=%h want=0", got_v); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    e0 = n_err;
    run_frame(FB, fw(1'b0, 4, 28'h7654321), 10);
    n_vec++; if (dut_regs !== '0 || ac_regs !== '0) begin
      n_bad++; $display("FAIL midrst_regs got=%h/%h want=0", dut_regs, ac_regs);
    end
    n_vec++; if (n_err !== e0) begin n_bad++; $display("FAIL midrst_err got=%0d want=0", n_err - e0); end
    n_vec++; if (spi_miso !== 1'b0 || update_stb !== 1'b0 || frame_error !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outs miso=%b stb=%b err=%b want=0", spi_miso, update_stb, frame_error);
    end
    run_frame(FB, fw(1'b0, 4, 28'h0C0FFEE), -1);
    run_frame(FB, fw(1'b0, 0, 28'h1), -1);
    n_vec++; if (dut_regs[111:84] !== 28'h0C0FFEE) begin
      n_bad++; $display("FAIL midrst_next_frame got=%h want=0c0ffee", dut_regs[111:84]);
    end
  endtask

  task automatic test_invalid_addr();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_frame(FB, fw(1'b0, 9, 28'hFEDCBA9), -1);
    run_frame(FB, fw(1'b0, 0, 28'h1), -1);
    n_vec++; if (dut_regs !== '0) begin n_bad++; $display("FAIL badaddr_regs got=%h want=0", dut_regs); end
    n_vec++; if (ac_regs !== '0) begin n_bad++; $display("FAIL badaddr_ac_regs got=%h want=0", ac_regs); end
    run_frame(FB, fw(1'b1, 9, '0), -1);
    n_vec++; if (got_v !== 64'h0) begin n_bad++; $display("FAIL badaddr_read got=%h want=0", got_v); end
  endtask

  task automatic test_random();
    int          kind, nbits;
    logic [63:0] w;
    for (int f = 0; f < 30; f++) begin
      kind  = $urandom_range(0, 9);
      nbits = FB;
      if (kind == 0) w = fw(1'b0, 0, 28'(($urandom << 1) | 1));
      else if (kind == 1) begin
        w = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: nbits = 0;
          1: nbits = 32;
          2: nbits = 34;
          default: nbits = $urandom_range(1, 40);
        endcase
      end else if (kind < 6) w = fw(1'b0, $urandom_range(0, 15), 28'($urandom));
      else w = fw(1'b1, $urandom_range(0, 15), 28'($urandom));
      run_frame(nbits, w, -1);
      n_vec++; if (dut_regs !== pack_regs(0)) begin n_bad++; $display("FAIL rnd%0d_regs got=%h want=%h", f, dut_regs, pack_regs(0)); end
      n_vec++; if (ac_regs !== pack_regs(1)) begin n_bad++; $display("FAIL rnd%0d_ac_regs got=%h want=%h", f, ac_regs, pack_regs(1)); end
      n_vec++; if (n_stb !== exp_stb || n_stb_ac !== exp_stb_ac) begin
        n_bad++; $display("FAIL rnd%0d_stb got=%0d/%0d want=%0d/%0d", f, n_stb, n_stb_ac, exp_stb, exp_stb_ac);
      end
      n_vec++; if (n_err !== exp_err || n_err_ac !== exp_err) begin
        n_bad++; $display("FAIL rnd%0d_err got=%0d/%0d want=%0d", f, n_err, n_err_ac, exp_err);
      end
      n_vec++; if (got_v !== exp_v) begin n_bad++; $display("FAIL rnd%0d_miso got=%h want=%h", f, got_v, exp_v); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_commit();
    test_auto_commit();
    test_readback();
    test_bad_length();
    test_reset_mid_frame();
    test_invalid_addr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_regbank.md
Name: spi_slave_regbank

Overview:
Parametrised SPI mode-0 slave register bank; successor to the fixed TinyDDS SPI register interface. It receives framed MOSI writes into a shadow register file of NUM_REGS x DATA_WIDTH words. Shadow contents are copied to the active outputs atomically on a commit command, or on each write when AUTO_COMMIT=1. Adds MISO readback of shadow registers, frame-length checking and an update strobe. It feeds the DDS core (frequency/phase/mode/gain/offset) in the system clock domain.

Parameters:
ADDR_WIDTH, 4, address field width; NUM_REGS <= 2^ADDR_WIDTH - 1
DATA_WIDTH, 28, data field and register width
NUM_REGS, 7, number of data registers, at addresses 1..NUM_REGS
SYNC_STAGES, 2, synchroniser flops on sclk/cs_n/mosi (>= 2)
AUTO_COMMIT, 0, 1 = every write also updates the active register at frame end

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
spi_clock  in  1  SPI SCLK, asynchronous, CPOL=0
spi_cs_n  in  1  SPI chip select, active-low
spi_mosi  in  1  SPI data in
spi_miso  out  1  SPI data out, registered
regs_active  out  NUM_REGS*DATA_WIDTH  active registers; register at address a occupies bits [a*DATA_WIDTH-1 -: DATA_WIDTH]
update_stb  out  1  one-cycle pulse when regs_active is loaded
frame_error  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low (rst_n).
- Reset state: shadow regs = 0, regs_active = 0, spi_miso = 0, update_stb = 0, frame_error = 0, bit counter = 0, frame tracker disarmed.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronised values. SPI clock must be <= clk/8.
- Frame format: FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH, MSB first: {rw, addr, data}. rw = 0 is a write; rw = 1 is a read.
- Framing: a cs_n falling edge arms the tracker and clears the bit counter. Each sclk rising edge while armed shifts mosi into the receive register and increments the counter, which saturates at FRAME_BITS+1. Sclk edges while disarmed or while cs_n is high are ignored.
- Reset mid-frame: the tracker stays disarmed until the next cs_n falling edge, so a partial frame is discarded with no error pulse.
- Frame end: detected on the cs_n rising edge in cycle N while armed; the tracker then disarms. All resulting register and strobe updates are visible at cycle N+1.
  - Write frame, count == FRAME_BITS, 1 <= addr <= NUM_REGS: shadow[addr] <= data. If AUTO_COMMIT=1, that active word is also updated and update_stb pulses.
  - Write frame to addr 0 with data[0] = 1 (commit): all shadow words are copied to regs_active in one cycle and update_stb pulses. data[0] = 0 does nothing.
  - Write frame with addr > NUM_REGS: ignored, no error.
  - Read frame with a valid count: no register change.
  - Count != FRAME_BITS (short, long, or zero bits): frame_error pulses at N+1 and no register changes.
- Readback: when the counter reaches 1 + ADDR_WIDTH on a read frame, the TX shifter loads shadow[addr]. It loads 0 for addr 0 or addr > NUM_REGS.
  - On each subsequent synchronised sclk falling edge, spi_miso presents the next TX bit, MSB first.
  - spi_miso = 0 whenever cs_n is high and during write frames.
- Simultaneous events: a cs_n rising edge and an sclk rising edge in the same cycle are resolved as the shift first, then the frame-end evaluation with the updated count. A new cs_n falling edge in cycle N+1 is accepted normally.
- Width rules: unused bits are zero. The receive register is exactly FRAME_BITS wide; extra bits shift out of its MSB, but the count still flags the error.

Decomposition:
- Package tinydds_spi_pkg holds:
  - function frame_bits(ADDR_WIDTH, DATA_WIDTH)
  - constants RW_WRITE = 1'b0, RW_READ = 1'b1, CTRL_ADDR = 0, CTRL_COMMIT_BIT = 0
- Sub-module spi_sync_edge: an N-stage synchroniser with registered rise/fall pulses, instantiated once each for sclk, cs_n and mosi (edge outputs unused for mosi).

Test Plan:
All scenarios use the default parameters (FRAME_BITS = 33).
1. Write 0x1234567 to addr 1, then commit (addr 0, data 1) -> shadow[1] = 0x1234567 after frame 1, regs_active unchanged; after frame 2, regs_active[27:0] = 0x1234567 with a single update_stb pulse one cycle after cs_n rises.
2. AUTO_COMMIT=1, write 0xABCDEF0 to addr 7 -> regs_active[195:168] = 0xABCDEF0 and update_stb pulses, with no commit frame needed.
3. Write addr 3 = 0x0000FFF, then a read frame of addr 3 -> MISO returns 0x0000FFF MSB first on the 28 sclk cycles after the address; spi_miso = 0 before and after the frame.
4. 32-bit and 34-bit write frames to addr 2 -> frame_error pulses once each; shadow[2] stays 0; no update_stb.
5. Assert rst_n low for 1 cycle mid-frame after 10 bits, then finish the frame -> all outputs 0, no write, no frame_error; the next full frame is accepted.
6. Write to addr 9 (> NUM_REGS) then commit -> regs_active = 0 everywhere; a read of addr 9 returns 0x0000000.
